// File: rtl/axi_uart.sv
// 8N1 UART with valid/ready byte handshakes on the SoC side.
// Independent TX and RX state machines share only the bit-period divisor.
module axi_uart #(
  parameter int DIVISOR = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIVISOR / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic [1:0]    rx_sync;
  logic          rx_s;

  // The byte is copied into tx_shift at the handshake, so tx_data is free to change mid-frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
      tx_ready <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          uart_tx <= 1'b1;
          if (tx_valid && tx_ready) begin
            tx_shift <= tx_data;
            tx_cnt   <= '0;
            tx_ready <= 1'b0;
            uart_tx  <= 1'b0;
            tx_state <= TX_START;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            uart_tx  <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              uart_tx  <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_ready <= 1'b1;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rx_sync <= 2'b11;
    else          rx_sync <= {rx_sync[0], uart_rx};
  end

  assign rx_s = rx_sync[1];

  // Samples land mid-bit: half a period after the falling edge, then every full period.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_s) begin
              rx_state <= RX_IDLE;
              // A consume on the same edge frees the holding register for the new byte.
              if (!rx_valid || rx_ready) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              rx_state  <= RX_WAIT_HIGH;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_s) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_uart.sv
// Self-checking bench for axi_uart at DIVISOR=8; expected serial waveforms and
// received bytes come from the 8N1 frame definition, not from the RTL structure.
module tb_axi_uart;
  localparam int D = 8;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = 8'h00;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       uart_tx;
  logic       uart_rx;
  logic       rx_drive = 1'b1;
  logic       loop_en = 1'b0;
  logic       frame_err;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int fe_count = 0;
  int ov_count = 0;

  assign uart_rx = loop_en ? uart_tx : rx_drive;

  axi_uart #(.DIVISOR(D)) dut (
    .clock(clock), .reset_n(reset_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .uart_tx(uart_tx), .uart_rx(uart_rx),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (frame_err === 1'b1) fe_count++;
    if (overrun === 1'b1) ov_count++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offers one byte and follows the line for the whole frame plus the ready-return cycle.
  task automatic send_tx(input logic [7:0] data, input bit hold_valid);
    logic [9:0] frame;
    logic exp_tx;
    logic exp_ready;
    frame = {1'b1, data, 1'b0};
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tx_ready_before_send: got %b, want 1", tx_ready);
    end
    tx_data = data;
    tx_valid = 1'b1;
    for (int k = 0; k <= 10 * D; k++) begin
      tick();
      if (k == 0 && !hold_valid) tx_valid = 1'b0;
      tx_data = 8'($urandom);
      exp_tx = (k < 10 * D) ? frame[k / D] : 1'b1;
      exp_ready = (k == 10 * D);
      checks++;
      if (uart_tx !== exp_tx) begin
        errors++;
        $display("[TB] FAIL tx_line byte %h cycle %0d: got %b, want %b", data, k, uart_tx, exp_tx);
      end
      checks++;
      if (tx_ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL tx_ready byte %h cycle %0d: got %b, want %b", data, k, tx_ready, exp_ready);
      end
    end
    if (!hold_valid) tx_valid = 1'b0;
  endtask

  // Drives one frame; optionally pulses rx_ready on the mid-stop sampling edge
  // (2 synchronizer cycles + 1 detect cycle + D/2 + 9 bits after the start edge).
  task automatic drive_rx(input logic [7:0] data, input logic stop_bit,
                          input int ready_tick, output bit dropped);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    dropped = 1'b0;
    for (int b = 0; b < 10; b++) begin
      rx_drive = frame[b];
      for (int t = 0; t < D; t++) begin
        if (b == 9 && ready_tick >= 0 && t == ready_tick) rx_ready = 1'b1;
        if (b == 9 && ready_tick >= 0 && t == ready_tick + 1) rx_ready = 1'b0;
        tick();
        if (b == 9 && rx_valid !== 1'b1) dropped = 1'b1;
      end
    end
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rx_valid_after_consume: got %b, want 0", rx_valid);
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks += 6;
    if (uart_tx !== 1'b1)   begin errors++; $display("[TB] FAIL reset_uart_tx: got %b, want 1", uart_tx); end
    if (tx_ready !== 1'b0)  begin errors++; $display("[TB] FAIL reset_tx_ready: got %b, want 0", tx_ready); end
    if (rx_valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_rx_valid: got %b, want 0", rx_valid); end
    if (rx_data !== 8'h00)  begin errors++; $display("[TB] FAIL reset_rx_data: got %h, want 00", rx_data); end
    if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b, want 0", frame_err); end
    if (overrun !== 1'b0)   begin errors++; $display("[TB] FAIL reset_overrun: got %b, want 0", overrun); end
    tick();
    tick();
    reset_n = 1'b1;
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL tx_ready_at_release: got %b, want 0", tx_ready); end
    tick();
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL tx_ready_first_edge: got %b, want 1", tx_ready); end
  endtask

  task automatic test_tx_basic();
    send_tx(8'h55, 1'b0);
    for (int i = 0; i < 2; i++) begin
      repeat ($urandom_range(0, 4)) tick();
      send_tx(8'($urandom), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    send_tx(8'($urandom), 1'b1);
    send_tx(8'($urandom), 1'b1);
    send_tx(8'($urandom), 1'b0);
  endtask

  task automatic test_rx_hold();
    bit dropped;
    rx_ready = 1'b0;
    drive_rx(8'hA3, 1'b1, -1, dropped);
    for (int i = 0; i < 3 * D; i++) begin
      tick();
      checks += 2;
      if (rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL rx_hold_valid: got %b, want 1", rx_valid); end
      if (rx_data !== 8'hA3) begin errors++; $display("[TB] FAIL rx_hold_data: got %h, want a3", rx_data); end
    end
    consume();
  endtask

  task automatic test_rx_random();
    bit dropped;
    logic [7:0] b;
    int fe0 = fe_count;
    int ov0 = ov_count;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 5)) tick();
      drive_rx(b, 1'b1, -1, dropped);
      tick();
      checks += 2;
      if (rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL rx_rand_valid %h: got %b, want 1", b, rx_valid); end
      if (rx_data !== b) begin errors++; $display("[TB] FAIL rx_rand_data: got %h, want %h", rx_data, b); end
      consume();
    end
    checks++;
    if (fe_count != fe0 || ov_count != ov0) begin
      errors++;
      $display("[TB] FAIL rx_rand_pulses: got fe=%0d ov=%0d, want fe=0 ov=0", fe_count - fe0, ov_count - ov0);
    end
  endtask

  task automatic test_glitch();
    bit dropped;
    int fe0 = fe_count;
    rx_drive = 1'b0;
    repeat (3) tick();
    rx_drive = 1'b1;
    repeat (2 * D) tick();
    checks += 2;
    if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL glitch_rx_valid: got %b, want 0", rx_valid); end
    if (fe_count != fe0) begin errors++; $display("[TB] FAIL glitch_frame_err: got %0d pulses, want 0", fe_count - fe0); end
    drive_rx(8'h5A, 1'b1, -1, dropped);
    tick();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL glitch_next_frame: got valid=%b data=%h, want valid=1 data=5a", rx_valid, rx_data);
    end
    consume();
  endtask

  task automatic test_frame_err();
    bit dropped;
    int fe0 = fe_count;
    drive_rx(8'h00, 1'b0, -1, dropped);
    repeat (40) tick();
    rx_drive = 1'b1;
    repeat (2 * D) tick();
    checks += 2;
    if (fe_count != fe0 + 1) begin errors++; $display("[TB] FAIL frame_err_count: got %0d, want 1", fe_count - fe0); end
    if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL frame_err_rx_valid: got %b, want 0", rx_valid); end
    drive_rx(8'h7E, 1'b1, -1, dropped);
    tick();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h7E) begin
      errors++;
      $display("[TB] FAIL frame_err_recover: got valid=%b data=%h, want valid=1 data=7e", rx_valid, rx_data);
    end
    consume();
  endtask

  task automatic test_overrun();
    bit dropped;
    int ov0 = ov_count;
    int ov1;
    rx_ready = 1'b0;
    drive_rx(8'h11, 1'b1, -1, dropped);
    drive_rx(8'h22, 1'b1, -1, dropped);
    tick();
    checks += 3;
    if (rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL overrun_valid: got %b, want 1", rx_valid); end
    if (rx_data !== 8'h11) begin errors++; $display("[TB] FAIL overrun_data: got %h, want 11", rx_data); end
    if (ov_count != ov0 + 1) begin errors++; $display("[TB] FAIL overrun_count: got %0d, want 1", ov_count - ov0); end
    consume();
    ov1 = ov_count;
    drive_rx(8'h11, 1'b1, -1, dropped);
    drive_rx(8'h22, 1'b1, 2 + D / 2, dropped);
    tick();
    checks += 4;
    if (dropped) begin errors++; $display("[TB] FAIL coincide_valid_gap: got a low rx_valid, want continuous 1"); end
    if (rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL coincide_valid: got %b, want 1", rx_valid); end
    if (rx_data !== 8'h22) begin errors++; $display("[TB] FAIL coincide_data: got %h, want 22", rx_data); end
    if (ov_count != ov1) begin errors++; $display("[TB] FAIL coincide_overrun: got %0d, want 0", ov_count - ov1); end
    consume();
  endtask

  task automatic test_concurrent();
    bit dropped;
    logic [7:0] a;
    logic [7:0] b;
    a = 8'($urandom);
    b = 8'($urandom);
    fork
      send_tx(a, 1'b0);
      drive_rx(b, 1'b1, -1, dropped);
    join
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== b) begin
      errors++;
      $display("[TB] FAIL concurrent_rx: got valid=%b data=%h, want valid=1 data=%h", rx_valid, rx_data, b);
    end
    consume();
  endtask

  task automatic test_reset_midframe();
    bit dropped;
    int fe0;
    int ov0;
    drive_rx(8'h96, 1'b1, -1, dropped);
    tick();
    tx_data = 8'($urandom);
    tx_valid = 1'b1;
    rx_drive = 1'b0;
    tick();
    tx_valid = 1'b0;
    repeat (3 * D) tick();
    reset_n = 1'b0;
    #1;
    checks += 6;
    if (uart_tx !== 1'b1)   begin errors++; $display("[TB] FAIL midreset_uart_tx: got %b, want 1", uart_tx); end
    if (tx_ready !== 1'b0)  begin errors++; $display("[TB] FAIL midreset_tx_ready: got %b, want 0", tx_ready); end
    if (rx_valid !== 1'b0)  begin errors++; $display("[TB] FAIL midreset_rx_valid: got %b, want 0", rx_valid); end
    if (rx_data !== 8'h00)  begin errors++; $display("[TB] FAIL midreset_rx_data: got %h, want 00", rx_data); end
    if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_frame_err: got %b, want 0", frame_err); end
    if (overrun !== 1'b0)   begin errors++; $display("[TB] FAIL midreset_overrun: got %b, want 0", overrun); end
    rx_drive = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    fe0 = fe_count;
    ov0 = ov_count;
    tick();
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready_return: got %b, want 1", tx_ready); end
    repeat (2 * D) tick();
    checks += 2;
    if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_partial_rx: got %b, want 0", rx_valid); end
    if (fe_count != fe0 || ov_count != ov0) begin
      errors++;
      $display("[TB] FAIL midreset_pulses: got fe=%0d ov=%0d, want 0", fe_count - fe0, ov_count - ov0);
    end
    loop_en = 1'b1;
    send_tx(8'hC3, 1'b0);
    tick();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hC3) begin
      errors++;
      $display("[TB] FAIL loopback: got valid=%b data=%h, want valid=1 data=c3", rx_valid, rx_data);
    end
    consume();
    loop_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_back_to_back();
    test_rx_hold();
    test_rx_random();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_concurrent();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/axi_uart.md
AXI_UART -- requirements
Module: axi_uart

Interface
REQ-001 Parameter DIVISOR, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 clock  input  1  single clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 tx_valid  input  1  byte offered by SoC for transmission.
REQ-005 tx_ready  output  1  transmitter can accept a byte.
REQ-006 tx_data  input  8  byte to transmit.
REQ-007 rx_valid  output  1  received byte available.
REQ-008 rx_ready  input  1  SoC consumes received byte.
REQ-009 rx_data  output  8  received byte.
REQ-010 uart_tx  output  1  serial line out, idle high.
REQ-011 uart_rx  input  1  serial line in, asynchronous to clock, idle high.
REQ-012 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-013 overrun  output  1  one-cycle pulse: received byte dropped because rx_valid still high.

Function
REQ-014 Frame format SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1, each bit exactly DIVISOR cycles.
REQ-015 TX handshake SHALL occur on a cycle with tx_valid && tx_ready; tx_data captured that cycle.
REQ-016 TX FSM SHALL have states IDLE, START, DATA, STOP; IDLE->START on handshake, START->DATA after DIVISOR cycles, DATA->STOP after 8 bits, STOP->IDLE after DIVISOR cycles.
REQ-017 uart_tx SHALL drive 0 starting the cycle after the handshake; total frame length SHALL be 10*DIVISOR cycles.
REQ-018 tx_ready SHALL be 1 only in IDLE; it SHALL fall the cycle after a handshake and rise the cycle after the stop bit completes (back-to-back frames with no idle gap beyond one cycle).
REQ-019 tx_data changes while tx_ready is low SHALL not affect the frame in flight.
REQ-020 uart_rx SHALL pass through a two-flop synchronizer before use; all RX decisions use the synchronized value.
REQ-021 RX FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-022 IDLE->START on synchronized uart_rx == 0; START samples after DIVISOR/2 cycles (integer floor); sample 1 -> IDLE (glitch rejected, no output), sample 0 -> DATA.
REQ-023 DATA SHALL sample one bit every DIVISOR cycles (mid-bit), shifting LSB first, 8 samples, then -> STOP.
REQ-024 STOP samples after DIVISOR cycles: 1 -> deliver byte, -> IDLE; 0 -> frame_err pulse, byte discarded, -> WAIT_HIGH.
REQ-025 WAIT_HIGH -> IDLE on first synchronized uart_rx == 1.
REQ-026 Delivery with rx_valid == 0: rx_data loaded and rx_valid set the following cycle.
REQ-027 rx_valid SHALL clear the cycle after rx_valid && rx_ready; rx_data SHALL hold until then.
REQ-028 Delivery while rx_valid == 1 and rx_ready == 0: old byte retained, new byte dropped, overrun pulses one cycle.
REQ-029 Delivery coinciding with rx_valid && rx_ready: new byte loaded, rx_valid stays 1, no overrun.
REQ-030 TX and RX SHALL operate fully independently and concurrently.
REQ-031 Bit counters SHALL be sized ceil(log2(DIVISOR)) bits and SHALL not wrap within a bit period.

Reset
REQ-032 reset_n low SHALL immediately force: uart_tx=1, tx_ready=0, rx_valid=0, rx_data=0, frame_err=0, overrun=0, both FSMs IDLE, synchronizer flops 1.
REQ-033 tx_ready SHALL rise the first clock edge after reset_n deasserts.
REQ-034 Reset mid-frame SHALL abandon the frame: uart_tx returns high immediately, partial RX byte discarded, no pulses.

Verification
REQ-035 DIVISOR=8, send tx_data=8'h55 -> uart_tx low cycles 1..8 after handshake, then 1,0,1,0,1,0,1,0 per 8 cycles, stop high; tx_ready high again at cycle 81.
REQ-036 DIVISOR=8, drive uart_rx frame for 8'hA3, rx_ready=0 -> rx_valid=1, rx_data=8'hA3, held until rx_ready pulsed.
REQ-037 DIVISOR=8, uart_rx low pulse of 3 cycles -> no rx_valid, no frame_err, FSM back to IDLE.
REQ-038 DIVISOR=8, frame 8'h00 with stop bit 0 then line held low 40 cycles -> one frame_err pulse, no rx_valid, next valid frame 8'h7E received correctly.
REQ-039 Two frames 8'h11 then 8'h22, rx_ready=0 -> rx_data=8'h11, one overrun pulse; repeat with rx_ready=1 at second delivery -> rx_data=8'h22, no overrun.
REQ-040 Assert reset_n low mid TX and mid RX frame -> outputs at reset values same cycle; after release, 8'hC3 loopback (uart_tx tied to uart_rx) returns 8'hC3.
